// File: rtl/riscv_pipe_pkg.sv
// Shared RV32 pipeline constants used by the fetch front end.
package riscv_pipe_pkg;
  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned ILEN_DEF = 32;
  localparam logic [31:0] RV32_NOP = 32'h0000_0013;
  localparam int unsigned PC_STEP  = 4;
endpackage

// File: rtl/fq_fifo.sv
// Synchronous FIFO with head look-ahead, occupancy count and a flush input.
module fq_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clr) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + AW'(1);
      if (pop)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) mem_q[wr_q] <= wdata;
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch buffer: sequential PC generation, in-order memory
// responses, DEPTH-entry decode queue and redirect flush of stale fetches.
module fetch_queue
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned      XLEN     = XLEN_DEF,
  parameter int unsigned      ILEN     = ILEN_DEF,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  localparam int unsigned     CW       = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            start,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  output logic [ILEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc,
  input  logic            out_ready,
  output logic [CW-1:0]   count
);
  localparam int unsigned DW = CW + 4;

  logic [XLEN-1:0]      fetch_pc_q, fetch_pc_d;
  logic [DW-1:0]        discard_q, discard_d;
  logic [CW-1:0]        q_count, pending;
  logic [ILEN+XLEN-1:0] q_head;
  logic [XLEN-1:0]      tag_head;
  logic [CW:0]          inflight;
  logic                 req_fire, rsp_drop, rsp_take, deq;

  assign inflight       = {1'b0, q_count} + {1'b0, pending};
  assign imem_req_valid = !start && !redirect && (inflight < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_drop       = imem_rsp_valid && (discard_q != '0);
  assign rsp_take       = imem_rsp_valid && (discard_q == '0) && (pending != '0);
  assign out_valid      = q_count != '0;
  assign deq            = out_valid && out_ready;

  fq_fifo #(.WIDTH(ILEN + XLEN), .DEPTH(DEPTH)) u_inst_q (
    .clk   (clk),
    .rst   (start),
    .clr   (redirect),
    .push  (rsp_take),
    .wdata ({imem_rsp_data, tag_head}),
    .pop   (deq),
    .head  (q_head),
    .count (q_count)
  );

  // The tag FIFO holds exactly one entry per live request, so its
  // occupancy doubles as the pending-request counter.
  fq_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_q (
    .clk   (clk),
    .rst   (start),
    .clr   (redirect),
    .push  (req_fire),
    .wdata (fetch_pc_q),
    .pop   (rsp_take),
    .head  (tag_head),
    .count (pending)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    if (redirect) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      discard_d  = discard_q + DW'(pending) - DW'(rsp_drop || rsp_take);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
      if (rsp_drop) discard_d = discard_q - DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      fetch_pc_q <= RESET_PC;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
    end
  end

  assign out_inst = out_valid ? q_head[ILEN+XLEN-1:XLEN] : '0;
  assign out_pc   = out_valid ? q_head[XLEN-1:0] : '0;
  assign count    = q_count;
endmodule

// File: tb/tb_fetch_queue.sv
// Randomised scoreboard bench for fetch_queue with an in-order memory model.
module tb_fetch_queue;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        start = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_inst, out_pc;
  logic [2:0]  count;

  fetch_queue #(.XLEN(32), .ILEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .start(start),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
    .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int unsigned due; bit good; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;

  mreq_t       mem_q[$];
  exp_t        sb[$];
  int          vectors = 0, miscompares = 0, deliveries = 0;
  int unsigned cyc = 0, last_due = 0, max_lat = 1, since = 0;
  bit          armed = 0, pushed_now = 0, stream_chk = 0;
  logic [31:0] m_pc;

  function automatic logic [31:0] img(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock of stimulus; the memory answers its oldest due request.
  task automatic step(input bit st, input bit rd, input logic [31:0] rpc,
                      input bit ordy, input bit mrdy, input bit rsp_en);
    @(posedge clk); #1;
    cyc++;
    start = st; redirect = rd; redirect_pc = rpc;
    out_ready = ordy; imem_req_ready = mrdy;
    imem_rsp_valid = 1'b0; imem_rsp_data = $urandom;
    pushed_now = 0;
    if (st) begin
      mem_q.delete();
      last_due = 0;
    end else begin
      if (rd) foreach (mem_q[i]) mem_q[i].good = 0;
      if (rsp_en && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = img(mem_q[0].addr);
        if (mem_q[0].good) begin
          sb.push_back('{mem_q[0].addr, img(mem_q[0].addr)});
          pushed_now = 1;
        end
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (armed) begin
      int    mcount, pend;
      bit    exp_rv;
      exp_t  e;
      mcount = sb.size() - int'(pushed_now);
      pend   = 0;
      foreach (mem_q[i]) if (mem_q[i].good) pend++;
      exp_rv = !start && !redirect && (mcount + pend < DEPTH);
      chk("count", 64'(count), 64'(mcount));
      chk("out_valid", 64'(out_valid), 64'(mcount != 0));
      if (!out_valid) chk("idle_out", {out_pc, out_inst}, 64'd0);
      chk("req_valid", 64'(imem_req_valid), 64'(exp_rv));
      if (stream_chk && since >= 2) chk("stream", 64'(out_valid), 64'd1);
      if (out_valid && out_ready && !start && !redirect && mcount > 0) begin
        e = sb.pop_front();
        chk("out_pc", 64'(out_pc), 64'(e.pc));
        chk("out_inst", 64'(out_inst), 64'(e.inst));
        deliveries++;
      end
      if (imem_rsp_valid && !start && mem_q.size() > 0) void'(mem_q.pop_front());
      if (imem_req_valid && imem_req_ready) begin
        int unsigned d;
        chk("req_addr", 64'(imem_req_addr), 64'(m_pc));
        d = cyc + $urandom_range(max_lat, 1);
        if (d < last_due) d = last_due;
        last_due = d;
        mem_q.push_back('{m_pc, d, 1'b1});
        m_pc = m_pc + 32'd4;
      end
      if (start) begin
        sb.delete(); m_pc = RESET_PC; since = 0;
      end else begin
        if (redirect) begin
          sb.delete(); m_pc = redirect_pc & ~32'h3;
        end
        since++;
      end
    end
  end

  initial begin
    m_pc = RESET_PC;
    // Reset, then full-rate streaming across the 32-bit PC wrap.
    step(1, 0, '0, 1, 1, 1);
    step(1, 0, '0, 1, 1, 1);
    armed = 1;
    stream_chk = 1;
    repeat (20) step(0, 0, '0, 1, 1, 1);
    stream_chk = 0;
    // Decode stall until the queue and request window saturate.
    repeat (10) step(0, 0, '0, 0, 1, 1);
    repeat (10) step(0, 0, '0, 1, 1, 1);
    // Redirect with slow memory and requests in flight.
    max_lat = 3;
    repeat (4) step(0, 0, '0, 1, 1, 1);
    step(0, 1, 32'h0000_0100, 1, 1, 1);
    repeat (12) step(0, 0, '0, 1, 1, 1);
    // Misaligned redirect immediately overridden by a second one.
    repeat (3) step(0, 0, '0, 1, 1, 1);
    step(0, 1, 32'h0000_0203, 1, 1, 1);
    step(0, 1, 32'h0000_0400, 1, 1, 1);
    repeat (12) step(0, 0, '0, 1, 1, 1);
    // Reset while the queue holds entries and requests are outstanding.
    max_lat = 2;
    repeat (5) step(0, 0, '0, 0, 1, 1);
    step(1, 0, '0, 0, 1, 1);
    max_lat = 1;
    repeat (10) step(0, 0, '0, 1, 1, 1);
    // Random traffic: latency, backpressure, redirects and resets.
    for (int i = 0; i < 3000; i++) begin
      bit st, rd;
      if (i % 200 == 0) max_lat = $urandom_range(4, 1);
      st = ($urandom % 150) == 0;
      rd = ($urandom % 20) == 0;
      step(st, rd, $urandom, ($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 4) != 0);
    end
    repeat (20) step(0, 0, '0, 1, 1, 1);
    @(negedge clk); #1;
    armed = 0;
    chk("deliveries", 64'(deliveries > 500), 64'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
